// File: rtl/mult_div_pkg.sv
// Shared funct codes and bus widths for the HI/LO multiply/divide unit.
package mult_div_pkg;

  localparam int FUNCT_BUS = 6;

  localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;

  localparam int DIV_CNT_W = 6;

  function automatic logic is_md_funct(input logic [FUNCT_BUS-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) ||
           (f == FUNCT_DIVU) || (f == FUNCT_MTHI) || (f == FUNCT_MTLO);
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// EX-stage request bus and HI/LO result bus of the multiply/divide unit.
interface mult_div_if #(parameter int DATA_WIDTH = 32);
  import mult_div_pkg::*;

  logic                  start;
  logic [FUNCT_BUS-1:0]  funct;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  flush;
  logic                  stall_req;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  done;

  modport master (output start, funct, rs_data, rt_data, flush,
                  input  stall_req, hi, lo, done);
  modport slave  (input  start, funct, rs_data, rt_data, flush,
                  output stall_req, hi, lo, done);

endinterface

// File: rtl/mult_div_div_iter.sv
// Radix-2 restoring divider with sign fixup; compiled only when
// MULT_DIV_DIVIDER_EN is defined.
`ifdef MULT_DIV_DIVIDER_EN
module div_iter
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int W = DATA_WIDTH;
  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DATA_WIDTH - 1);

  logic                 running;
  logic [DIV_CNT_W-1:0] cnt;
  logic [W-1:0]         quo;
  logic [W-1:0]         rem;
  logic [W-1:0]         dvs;
  logic                 neg_q;
  logic                 neg_r;
  logic [W-1:0]         abs_dividend;
  logic [W-1:0]         abs_divisor;
  logic [W:0]           shifted;
  logic [W:0]           diff;

  assign abs_dividend = (is_signed && dividend[W-1]) ? -dividend : dividend;
  assign abs_divisor  = (is_signed && divisor[W-1])  ? -divisor  : divisor;

  // The partial remainder stays below the divisor, so bit W of diff is the borrow.
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      quo     <= abs_dividend;
      rem     <= '0;
      dvs     <= abs_divisor;
      neg_q   <= is_signed && (dividend[W-1] ^ divisor[W-1]);
      neg_r   <= is_signed && dividend[W-1];
    end else if (running) begin
      if (!diff[W]) begin
        rem <= diff[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= shifted[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
      cnt <= cnt + DIV_CNT_W'(1);
      if (cnt == LAST_STEP) running <= 1'b0;
    end
  end

  // valid marks the final step; the corrected result is on quotient/remainder next cycle.
  assign busy      = running;
  assign valid     = running && (cnt == LAST_STEP);
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule
`endif

// File: rtl/mult_div.sv
// HI/LO multiply/divide unit: one-cycle MULT/MULTU/MTHI/MTLO; iterative
// DIV/DIVU only when MULT_DIV_DIVIDER_EN is defined, else DIV/DIVU are no-ops.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  mult_div_if.slave bus
);

  localparam int W = DATA_WIDTH;

`ifdef MULT_DIV_DIVIDER_EN
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE} state_t;
`endif

  state_t         state;
  state_t         next_state;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           done_q;
  logic [W-1:0]   hi_d;
  logic [W-1:0]   lo_d;
  logic           done_d;
  logic           stall;
  logic           accept;
  logic           div_by_zero;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] prod_u;

  assign accept      = bus.start && !bus.flush && (state == IDLE) && is_md_funct(bus.funct);
  assign div_by_zero = (bus.rt_data == '0);
  assign prod_s      = {{W{bus.rs_data[W-1]}}, bus.rs_data} * {{W{bus.rt_data[W-1]}}, bus.rt_data};
  assign prod_u      = {{W{1'b0}}, bus.rs_data} * {{W{1'b0}}, bus.rt_data};

`ifdef MULT_DIV_DIVIDER_EN
  logic         div_go;
  logic         div_busy;
  logic         div_valid;
  logic [W-1:0] div_quo;
  logic [W-1:0] div_rem;

  div_iter #(.DATA_WIDTH(W)) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (bus.flush),
    .start     (div_go),
    .is_signed (bus.funct == FUNCT_DIV),
    .dividend  (bus.rs_data),
    .divisor   (bus.rt_data),
    .busy      (div_busy),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_comb begin
    next_state = state;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    stall      = 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
    div_go     = 1'b0;
`endif
    if (bus.flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.funct)
              FUNCT_MULT:  begin {hi_d, lo_d} = prod_s; done_d = 1'b1; end
              FUNCT_MULTU: begin {hi_d, lo_d} = prod_u; done_d = 1'b1; end
              FUNCT_MTHI:  begin hi_d = bus.rs_data;    done_d = 1'b1; end
              FUNCT_MTLO:  begin lo_d = bus.rs_data;    done_d = 1'b1; end
              default: begin
                if (div_by_zero) begin
                  hi_d   = bus.rs_data;
                  lo_d   = '1;
                  done_d = 1'b1;
                end else begin
`ifdef MULT_DIV_DIVIDER_EN
                  div_go     = 1'b1;
                  stall      = 1'b1;
                  next_state = DIV_RUN;
`else
                  done_d     = 1'b1;
`endif
                end
              end
            endcase
          end
        end
`ifdef MULT_DIV_DIVIDER_EN
        DIV_RUN: begin
          stall = 1'b1;
          if (div_valid)     next_state = DIV_FIX;
          else if (!div_busy) next_state = IDLE;
        end
        DIV_FIX: begin
          stall      = 1'b1;
          hi_d       = div_rem;
          lo_d       = div_quo;
          done_d     = 1'b1;
          next_state = IDLE;
        end
`endif
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  // Reset must mask stall even if a divide is presented while rst_n is low.
  assign bus.stall_req = stall && rst_n;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mult_div.sv
// Randomized self-checking bench for mult_div against an arithmetic model;
// expectations follow MULT_DIV_DIVIDER_EN when it is defined.
module tb_mult_div;
  import mult_div_pkg::*;

`ifdef MULT_DIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DIV_STALLS   = DIV_EN ? 34 : 0;
  localparam int FLUSH_STALLS = DIV_EN ? 11 : 0;
  localparam int FLUSH_DONES  = DIV_EN ? 0 : 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   failCount  = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  always #5 clk = ~clk;

  mult_div_if #(.DATA_WIDTH(32)) bus ();
  mult_div #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Architectural result of one instruction, from plain integer arithmetic.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] nh, output logic [31:0] nl,
                                output int stalls, output bit dn);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = 64'(a);
    ub = 64'(b);
    nh = expHi;
    nl = expLo;
    stalls = 0;
    dn = 1'b1;
    case (f)
      FUNCT_MULT:  {nh, nl} = sa * sb;
      FUNCT_MULTU: {nh, nl} = ua * ub;
      FUNCT_MTHI:  nh = a;
      FUNCT_MTLO:  nl = a;
      FUNCT_DIV, FUNCT_DIVU: begin
        if (b == 32'd0) begin
          nh = a;
          nl = 32'hFFFF_FFFF;
        end else if (DIV_EN) begin
          stalls = DIV_STALLS;
          if (f == FUNCT_DIV) begin
            sq = sa / sb; sr = sa % sb;
            nl = sq[31:0]; nh = sr[31:0];
          end else begin
            uq = ua / ub; ur = ua % ub;
            nl = uq[31:0]; nh = ur[31:0];
          end
        end
      end
      default: dn = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] randFunct();
    logic [5:0] f;
    case ($urandom_range(0, 6))
      0: f = FUNCT_MULT;
      1: f = FUNCT_MULTU;
      2: f = FUNCT_DIV;
      3: f = FUNCT_DIVU;
      4: f = FUNCT_MTHI;
      5: f = FUNCT_MTLO;
      default: begin
        f = 6'($urandom);
        while (f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO})
          f = 6'($urandom);
      end
    endcase
    return f;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one instruction, holds it through any stall, then checks result and done pulse.
  task automatic applyStimulus(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl, prevHi, prevLo;
    int expStalls, stalls;
    bit expDone;
    prevHi = expHi;
    prevLo = expLo;
    model(f, a, b, nh, nl, expStalls, expDone);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct = f; bus.rs_data = a; bus.rt_data = b;
    stalls = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.stall_req) break;
      stalls++;
      checkOutput({name, "_hold"}, {bus.hi, bus.lo}, {prevHi, prevLo});
      @(posedge clk); #1;
      if (c + 1 < expStalls) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.funct   = randFunct();
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (stalls == 0) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
    end
    checkOutput({name, "_stall"}, 64'(stalls), 64'(expStalls));
    checkOutput({name, "_done"}, 64'(bus.done), 64'(expDone));
    checkOutput({name, "_hilo"}, {bus.hi, bus.lo}, {nh, nl});
    expHi = nh;
    expLo = nl;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, "_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic flushTest();
    int stalls, dones;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct = FUNCT_DIVU; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
    stalls = 0;
    dones  = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 11) checkOutput("flush_stall_drop", 64'(bus.stall_req), 64'd0);
      else if (bus.stall_req) stalls++;
      if (bus.done) dones++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = (c + 1 == 11);
    end
    checkOutput("flush_stalls", 64'(stalls), 64'(FLUSH_STALLS));
    checkOutput("flush_dones", 64'(dones), 64'(FLUSH_DONES));
    checkOutput("flush_hilo", {bus.hi, bus.lo}, {expHi, expLo});
  endtask

  task automatic flushStartTest();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1;
    bus.funct = FUNCT_DIVU; bus.rs_data = 32'd99; bus.rt_data = 32'd5;
    @(negedge clk);
    checkOutput("flush_prio_stall", 64'(bus.stall_req), 64'd0);
    @(posedge clk); #1;
    bus.funct = FUNCT_MULT; bus.rs_data = 32'h1234_5679; bus.rt_data = 32'h0000_0011;
    @(negedge clk);
    checkOutput("flush_prio_done1", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_prio_done2", 64'(bus.done), 64'd0);
    checkOutput("flush_prio_hilo", {bus.hi, bus.lo}, {expHi, expLo});
  endtask

  task automatic resetTest();
    int dones, stalls;
    applyStimulus("rst_pre_hi", FUNCT_MTHI, 32'hCAFE_0001, 32'd0);
    applyStimulus("rst_pre_lo", FUNCT_MTLO, 32'hBEEF_0002, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct = FUNCT_DIVU; bus.rs_data = 32'd5000; bus.rt_data = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    checkOutput("rst_mid_stall", 64'(bus.stall_req), 64'd0);
    checkOutput("rst_mid_done", 64'(bus.done), 64'd0);
    expHi = '0;
    expLo = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    dones  = 0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.stall_req) stalls++;
    end
    checkOutput("rst_after_dones", 64'(dones), 64'd0);
    checkOutput("rst_after_stalls", 64'(stalls), 64'd0);
    checkOutput("rst_after_hilo", {bus.hi, bus.lo}, 64'd0);
  endtask

  initial begin
    logic [5:0] f;
    rst_n = 1'b0;
    bus.start = 1'b1; bus.funct = FUNCT_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    bus.flush = 1'b0;
    #12;
    checkOutput("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_stall", 64'(bus.stall_req), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    applyStimulus("mult_neg", FUNCT_MULT, 32'hFFFF_FFFE, 32'd3);
    checkOutput("mult_neg_lit", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    applyStimulus("multu_big", FUNCT_MULTU, 32'hFFFF_FFFE, 32'd3);
    checkOutput("multu_big_lit", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);
    applyStimulus("mthi", FUNCT_MTHI, 32'hA5A5_0001, 32'd0);
    applyStimulus("mtlo", FUNCT_MTLO, 32'h5A5A_0002, 32'd0);
    applyStimulus("bad_funct", 6'h20, 32'h1111_1111, 32'h2222_2222);
    applyStimulus("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7);
    applyStimulus("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("div_by0", FUNCT_DIV, 32'd5, 32'd0);
    applyStimulus("divu_by0", FUNCT_DIVU, 32'hDEAD_BEEF, 32'd0);
    applyStimulus("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    flushTest();
    applyStimulus("post_flush", FUNCT_MULTU, 32'd12345, 32'd678);
    flushStartTest();

    for (int i = 0; i < 40; i++) begin
      f = randFunct();
      applyStimulus($sformatf("rand%0d", i), f, randOperand(), randOperand());
    end

    resetTest();
    applyStimulus("post_reset", FUNCT_DIV, 32'hFFFF_FF9C, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  EX-stage instruction valid this cycle.
REQ-005 SHALL have port funct  input  6  ALU function code produced by the ID-stage funct generator.
REQ-006 SHALL have ports rs_data and rt_data  input  DATA_WIDTH  each, dividend/multiplicand and divisor/multiplier.
REQ-007 SHALL have port flush  input  1  pipeline flush (exception or branch squash).
REQ-008 SHALL have port stall_req  output  1  freezes IF/ID/EX while high.
REQ-009 SHALL have ports hi and lo  output  DATA_WIDTH  each, architectural HI/LO registers.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a HI/LO write completes.

Function
REQ-011 SHALL act only when start=1 and funct is MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11 or MTLO 0x13; any other funct leaves all state unchanged.
REQ-012 SHALL complete MULT/MULTU in one cycle: {hi,lo} gets the signed/unsigned 64-bit product at the next edge, stall_req stays 0, and done=1 in the following cycle.
REQ-013 SHALL complete MTHI/MTLO in one cycle: hi (respectively lo) gets rs_data at the next edge, and done=1 in the following cycle.
REQ-014 SHALL use state machine IDLE -> DIV_RUN -> DIV_FIX -> IDLE for DIV/DIVU with a nonzero divisor.
REQ-015 SHALL, on accepting a DIV/DIVU in IDLE, capture absolute operand values (DIV) or raw values (DIVU) and the quotient/remainder signs, then enter DIV_RUN.
REQ-016 SHALL perform one radix-2 restoring step per cycle in DIV_RUN, using a 6-bit iteration counter, for exactly 32 cycles before entering DIV_FIX.
REQ-017 SHALL in DIV_FIX apply sign correction: quotient negated when operand signs differ; remainder takes the dividend's sign. It SHALL then write lo=quotient and hi=remainder at the DIV_FIX edge and return to IDLE.
REQ-018 SHALL drive stall_req combinationally high in the accept cycle and in every DIV_RUN and DIV_FIX cycle (34 cycles total), and low in the cycle after DIV_FIX, in which done=1.
REQ-019 SHALL complete a zero-divisor divide in one cycle with no stall: hi=rs_data, lo=all ones, and done=1 in the next cycle.
REQ-020 SHALL ignore start while not in IDLE; the stalled pipeline re-presents nothing new.
REQ-021 SHALL, on flush in any state, return to IDLE at the next edge with hi/lo unchanged, no done pulse, and stall_req dropping combinationally in the flush cycle.
REQ-022 SHALL give flush priority over start in the same cycle, so that no operation is accepted.
REQ-023 SHALL keep hi/lo stable during a divide; hi/lo hold the last completed values until the DIV_FIX write.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, hi=0, lo=0, done=0, stall_req=0 and iteration counter=0, asynchronously.
REQ-025 SHALL, if reset occurs mid-divide, discard the operation with no HI/LO write after release.

Configuration
REQ-026 SHALL compile the divider (DIV_RUN/DIV_FIX, divider datapath) only when macro MULT_DIV_DIVIDER_EN is defined.
REQ-027 SHALL, without MULT_DIV_DIVIDER_EN, treat DIV/DIVU as one-cycle no-ops: hi/lo unchanged, done=1 in the next cycle, stall_req never asserted.

Structure
REQ-028 SHALL take funct code constants (FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO) and FUNCT_BUS from the shared funct/bus definition includes; state encodings are local.
REQ-029 SHALL isolate the iterative divider (operands, counter, partial remainder, sign fixup) in one sub-module named div_iter, with a start/busy/valid handshake.

Verification
REQ-030 SHALL cover: MULT rs=0xFFFFFFFE, rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA one cycle later, and stall_req never high.
REQ-031 SHALL cover: DIVU rs=100, rt=7 -> stall_req high for 34 cycles, then lo=14, hi=2, and done for 1 cycle.
REQ-032 SHALL cover: DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-033 SHALL cover: DIV rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF next cycle, with no stall.
REQ-034 SHALL cover: DIVU accepted, then flush at iteration 10 -> IDLE next edge, hi/lo retain prior values, and no done pulse.
REQ-035 SHALL cover: rst_n low during DIV_RUN -> immediately hi=lo=0, stall_req=0, with no write after release.
